// File: rtl/demux_8out_buf.sv
// Write-side distributor: steers one accepted word per cycle into one of N_OUT
// registered slots, picked by an explicit select or by a round-robin pointer.
//
// Each slot behaves as a two-state holder tracked by its out_valid bit:
//   state | meaning
//   EMPTY | out_valid[i]=0, slot may be written, out_data[i] keeps last word
//   FULL  | out_valid[i]=1, word waits for out_ack[i]
module demux_8out_buf #(
    parameter int DATA_W = 64,
    parameter int N_OUT  = 8,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           auto_mode,
    output logic [N_OUT-1:0][DATA_W-1:0]   out_data,
    output logic [N_OUT-1:0]               out_valid,
    input  logic [N_OUT-1:0]               out_ack,
    output logic [SEL_W-1:0]               rr_ptr
);

    logic [SEL_W-1:0] dest;
    logic             accept;
    logic [N_OUT-1:0] wr_en;

    always_comb begin
        dest     = auto_mode ? rr_ptr : sel;
        in_ready = !reset && (!out_valid[dest] || out_ack[dest]);
        accept   = in_valid && in_ready;
        wr_en    = accept ? (N_OUT'(1) << dest) : '0;
    end

    // A write to a slot takes priority over its ack so back-to-back
    // handoffs to the same sink leave no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_en[i]) begin
                    out_data[i]  <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (out_ack[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept && auto_mode) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

endmodule
